// File: rtl/fat32_mount_sequencer.sv
// FAT32 mount sequencer: walks MBR -> boot sector through a single-outstanding sector reader
// and publishes partition, FAT, root-directory and cluster layout as absolute sector numbers.
module fat32_mount_sequencer #(
  parameter int         theSizeofSectors = 512,
  parameter logic [7:0] FAT32TypeA       = 8'h0B,
  parameter logic [7:0] FAT32TypeB       = 8'h0C
) (
  input  logic        Clock,
  input  logic        sys_rst,
  input  logic        start,
  output logic        readRequest,
  output logic [31:0] readSector,
  input  logic        readAck,
  input  logic        byteValid,
  input  logic [8:0]  byteAddress,
  input  logic [7:0]  byteData,
  input  logic        sectorDone,
  output logic        mountDone,
  output logic        mountError,
  output logic [1:0]  errorCode,
  output logic [31:0] partitionStart,
  output logic [31:0] fatStartSector,
  output logic [31:0] rootDirSector,
  output logic [7:0]  sectorsPerCluster,
  output logic [31:0] rootCluster
);

  typedef enum logic [3:0] {
    IDLE, REQ_MBR, RX_MBR, CHK_MBR, REQ_DBR, RX_DBR, CHK_DBR, CALC, DONE, ERROR
  } state_t;

  state_t state;

  logic [7:0]  cap_type;
  logic [31:0] cap_lba;
  logic [15:0] cap_bps;
  logic [7:0]  cap_spc;
  logic [15:0] cap_rsvd;
  logic [7:0]  cap_nfat;
  logic [31:0] cap_fatsz;
  logic [31:0] cap_root;
  logic [7:0]  cap_sig0;
  logic [7:0]  cap_sig1;

  logic [31:0] calc_acc;
  logic [7:0]  calc_count;

  logic sig_ok;
  logic type_ok;
  logic bps_ok;
  logic bpb_ok;

  assign sig_ok  = (cap_sig0 == 8'h55) && (cap_sig1 == 8'hAA);
  assign type_ok = (cap_type == FAT32TypeA) || (cap_type == FAT32TypeB);
  assign bps_ok  = (cap_bps == 16'(theSizeofSectors));
  assign bpb_ok  = sig_ok && bps_ok && (cap_spc != 8'd0) && (cap_nfat != 8'd0);

  always_ff @(posedge Clock or posedge sys_rst) begin
    if (sys_rst) begin
      state             <= IDLE;
      readRequest       <= 1'b0;
      readSector        <= '0;
      mountDone         <= 1'b0;
      mountError        <= 1'b0;
      errorCode         <= 2'd0;
      partitionStart    <= '0;
      fatStartSector    <= '0;
      rootDirSector     <= '0;
      sectorsPerCluster <= '0;
      rootCluster       <= '0;
      cap_type          <= '0;
      cap_lba           <= '0;
      cap_bps           <= '0;
      cap_spc           <= '0;
      cap_rsvd          <= '0;
      cap_nfat          <= '0;
      cap_fatsz         <= '0;
      cap_root          <= '0;
      cap_sig0          <= '0;
      cap_sig1          <= '0;
      calc_acc          <= '0;
      calc_count        <= '0;
    end else begin
      // Field capture happens before the state update so a byte coincident with sectorDone counts.
      if ((state == RX_MBR || state == RX_DBR) && byteValid) begin
        case (byteAddress)
          9'h1C2: cap_type        <= byteData;
          9'h1C6: cap_lba[7:0]    <= byteData;
          9'h1C7: cap_lba[15:8]   <= byteData;
          9'h1C8: cap_lba[23:16]  <= byteData;
          9'h1C9: cap_lba[31:24]  <= byteData;
          9'h00B: cap_bps[7:0]    <= byteData;
          9'h00C: cap_bps[15:8]   <= byteData;
          9'h00D: cap_spc         <= byteData;
          9'h00E: cap_rsvd[7:0]   <= byteData;
          9'h00F: cap_rsvd[15:8]  <= byteData;
          9'h010: cap_nfat        <= byteData;
          9'h024: cap_fatsz[7:0]  <= byteData;
          9'h025: cap_fatsz[15:8] <= byteData;
          9'h026: cap_fatsz[23:16] <= byteData;
          9'h027: cap_fatsz[31:24] <= byteData;
          9'h02C: cap_root[7:0]   <= byteData;
          9'h02D: cap_root[15:8]  <= byteData;
          9'h02E: cap_root[23:16] <= byteData;
          9'h02F: cap_root[31:24] <= byteData;
          9'h1FE: cap_sig0        <= byteData;
          9'h1FF: cap_sig1        <= byteData;
          default: ;
        endcase
      end

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            mountDone         <= 1'b0;
            mountError        <= 1'b0;
            errorCode         <= 2'd0;
            partitionStart    <= '0;
            fatStartSector    <= '0;
            rootDirSector     <= '0;
            sectorsPerCluster <= '0;
            rootCluster       <= '0;
            readSector        <= '0;
            readRequest       <= 1'b1;
            state             <= REQ_MBR;
          end
        end

        REQ_MBR, REQ_DBR: begin
          if (readAck) begin
            readRequest <= 1'b0;
            cap_type    <= '0;
            cap_lba     <= '0;
            cap_bps     <= '0;
            cap_spc     <= '0;
            cap_rsvd    <= '0;
            cap_nfat    <= '0;
            cap_fatsz   <= '0;
            cap_root    <= '0;
            cap_sig0    <= '0;
            cap_sig1    <= '0;
            state       <= (state == REQ_MBR) ? RX_MBR : RX_DBR;
          end
        end

        RX_MBR: if (sectorDone) state <= CHK_MBR;

        RX_DBR: if (sectorDone) state <= CHK_DBR;

        CHK_MBR: begin
          if (!sig_ok) begin
            mountError <= 1'b1;
            errorCode  <= 2'd1;
            state      <= ERROR;
          end else if (type_ok) begin
            partitionStart <= cap_lba;
            readSector     <= cap_lba;
            readRequest    <= 1'b1;
            state          <= REQ_DBR;
          end else if (bps_ok) begin
            // Superfloppy: the BPB check is folded in here so the done latency matches the DBR path.
            partitionStart <= '0;
            if (!bpb_ok) begin
              mountError <= 1'b1;
              errorCode  <= 2'd2;
              state      <= ERROR;
            end else begin
              fatStartSector    <= {16'h0000, cap_rsvd};
              sectorsPerCluster <= cap_spc;
              rootCluster       <= cap_root;
              calc_acc          <= {16'h0000, cap_rsvd};
              calc_count        <= cap_nfat;
              state             <= CALC;
            end
          end else begin
            mountError <= 1'b1;
            errorCode  <= 2'd3;
            state      <= ERROR;
          end
        end

        CHK_DBR: begin
          if (!bpb_ok) begin
            mountError <= 1'b1;
            errorCode  <= 2'd2;
            state      <= ERROR;
          end else begin
            fatStartSector    <= partitionStart + {16'h0000, cap_rsvd};
            sectorsPerCluster <= cap_spc;
            rootCluster       <= cap_root;
            calc_acc          <= partitionStart + {16'h0000, cap_rsvd};
            calc_count        <= cap_nfat;
            state             <= CALC;
          end
        end

        // nFAT x FATsz by repeated addition, one FAT copy per cycle.
        CALC: begin
          calc_acc   <= calc_acc + cap_fatsz;
          calc_count <= calc_count - 8'd1;
          if (calc_count == 8'd1) begin
            rootDirSector <= calc_acc + cap_fatsz;
            mountDone     <= 1'b1;
            state         <= DONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fat32_mount_sequencer.sv
// Directed bench for fat32_mount_sequencer: streams hand-built MBR/BPB sectors and checks
// request handshakes, latency, layout results, error codes and reset behaviour.
module tb_fat32_mount_sequencer;

  logic        Clock = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic        readAck = 1'b0;
  logic        byteValid = 1'b0;
  logic [8:0]  byteAddress = '0;
  logic [7:0]  byteData = '0;
  logic        sectorDone = 1'b0;
  logic        readRequest;
  logic [31:0] readSector;
  logic        mountDone;
  logic        mountError;
  logic [1:0]  errorCode;
  logic [31:0] partitionStart;
  logic [31:0] fatStartSector;
  logic [31:0] rootDirSector;
  logic [7:0]  sectorsPerCluster;
  logic [31:0] rootCluster;

  int checks = 0;
  int errors = 0;
  logic [7:0] sec [512];

  fat32_mount_sequencer dut (
    .Clock(Clock), .sys_rst(sys_rst), .start(start),
    .readRequest(readRequest), .readSector(readSector), .readAck(readAck),
    .byteValid(byteValid), .byteAddress(byteAddress), .byteData(byteData),
    .sectorDone(sectorDone), .mountDone(mountDone), .mountError(mountError),
    .errorCode(errorCode), .partitionStart(partitionStart),
    .fatStartSector(fatStartSector), .rootDirSector(rootDirSector),
    .sectorsPerCluster(sectorsPerCluster), .rootCluster(rootCluster)
  );

  always #5 Clock = ~Clock;

  task automatic clear_sec();
    for (int i = 0; i < 512; i++) sec[i] = 8'h00;
  endtask

  task automatic put_sig(input logic [7:0] a, input logic [7:0] b);
    sec[510] = a;
    sec[511] = b;
  endtask

  task automatic put_mbr(input logic [7:0] ptype, input logic [31:0] lba);
    sec[9'h1C2] = ptype;
    for (int i = 0; i < 4; i++) sec[9'h1C6 + i] = lba[8*i +: 8];
  endtask

  task automatic put_bpb(input logic [15:0] bps, input logic [7:0] spc, input logic [15:0] rsvd,
                         input logic [7:0] nfat, input logic [31:0] fatsz, input logic [31:0] root);
    sec[9'h00B] = bps[7:0];
    sec[9'h00C] = bps[15:8];
    sec[9'h00D] = spc;
    sec[9'h00E] = rsvd[7:0];
    sec[9'h00F] = rsvd[15:8];
    sec[9'h010] = nfat;
    for (int i = 0; i < 4; i++) sec[9'h024 + i] = fatsz[8*i +: 8];
    for (int i = 0; i < 4; i++) sec[9'h02C + i] = root[8*i +: 8];
  endtask

  // Streams the first n bytes; with done set, sectorDone follows one cycle after the last byte.
  // Returns at the falling edge just after the sectorDone edge.
  task automatic send_bytes(input int n, input bit done);
    for (int i = 0; i < n; i++) begin
      @(negedge Clock);
      byteValid   = 1'b1;
      byteAddress = 9'(i);
      byteData    = sec[i];
    end
    @(negedge Clock);
    byteValid = 1'b0;
    if (done) begin
      sectorDone = 1'b1;
      @(negedge Clock);
      sectorDone = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge Clock);
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic ack_read();
    readAck = 1'b1;
    @(negedge Clock);
    readAck = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clock);
    checks++;
    if (readRequest !== 1'b0 || mountDone !== 1'b0 || mountError !== 1'b0 || errorCode !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b done=%b err=%b code=%0d required all 0",
               readRequest, mountDone, mountError, errorCode);
    end
    checks++;
    if (readSector !== 0 || partitionStart !== 0 || fatStartSector !== 0 || rootDirSector !== 0 ||
        sectorsPerCluster !== 0 || rootCluster !== 0) begin
      errors++;
      $display("FAIL reset_layout: sec=%h ps=%h fat=%h root=%h spc=%h rc=%h required all 0",
               readSector, partitionStart, fatStartSector, rootDirSector, sectorsPerCluster, rootCluster);
    end
    sys_rst = 1'b0;
    pulse_start();
    checks++;
    if (readRequest !== 1'b1) begin
      errors++;
      $display("FAIL start_req: readRequest=%b required 1", readRequest);
    end
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if (readRequest !== 1'b0) begin
      errors++;
      $display("FAIL reset_drops_req: readRequest=%b required 0", readRequest);
    end
    @(negedge Clock);
    sys_rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_normal_mount(input string tag);
    pulse_start();
    checks++;
    if (readRequest !== 1'b1 || readSector !== 32'h0) begin
      errors++;
      $display("FAIL %s mbr_req: req=%b sector=%h required 1/00000000", tag, readRequest, readSector);
    end
    ack_read();
    checks++;
    if (readRequest !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_drop: readRequest=%b required 0", tag, readRequest);
    end
    clear_sec();
    put_mbr(8'h0C, 32'h0000_2000);
    put_sig(8'h55, 8'hAA);
    send_bytes(512, 1'b1);
    checks++;
    if (readRequest !== 1'b0) begin
      errors++;
      $display("FAIL %s dbr_req_early: readRequest=%b required 0 after S", tag, readRequest);
    end
    @(negedge Clock);
    checks++;
    if (readRequest !== 1'b1 || readSector !== 32'h2000) begin
      errors++;
      $display("FAIL %s dbr_req: req=%b sector=%h required 1/00002000", tag, readRequest, readSector);
    end
    ack_read();
    clear_sec();
    put_bpb(16'd512, 8'd8, 16'h0020, 8'd2, 32'h0000_03C1, 32'd2);
    put_sig(8'h55, 8'hAA);
    send_bytes(512, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (mountDone !== 1'b0) begin
        errors++;
        $display("FAIL %s done_early: mountDone=%b at S+%0d required 0", tag, mountDone, c);
      end
      @(negedge Clock);
    end
    checks++;
    if (mountDone !== 1'b1 || mountError !== 1'b0) begin
      errors++;
      $display("FAIL %s done_latency: done=%b err=%b at S+3 required 1/0", tag, mountDone, mountError);
    end
    checks++;
    if (partitionStart !== 32'h2000 || fatStartSector !== 32'h2020 || rootDirSector !== 32'h27A2) begin
      errors++;
      $display("FAIL %s layout: ps=%h fat=%h root=%h required 00002000/00002020/000027a2",
               tag, partitionStart, fatStartSector, rootDirSector);
    end
    checks++;
    if (sectorsPerCluster !== 8'd8 || rootCluster !== 32'd2) begin
      errors++;
      $display("FAIL %s cluster: spc=%0d rootClus=%0d required 8/2", tag, sectorsPerCluster, rootCluster);
    end
    $display("test_normal_mount %s: fat=%h root=%h", tag, fatStartSector, rootDirSector);
  endtask

  task automatic test_superfloppy();
    bit saw_req;
    pulse_start();
    ack_read();
    clear_sec();
    put_mbr(8'h00, 32'h0000_5555);
    put_bpb(16'd512, 8'd4, 16'h0020, 8'd1, 32'h0000_0100, 32'd2);
    put_sig(8'h55, 8'hAA);
    send_bytes(512, 1'b1);
    @(negedge Clock);
    checks++;
    if (mountDone !== 1'b0) begin
      errors++;
      $display("FAIL sf_done_early: mountDone=%b at S+1 required 0", mountDone);
    end
    @(negedge Clock);
    checks++;
    if (mountDone !== 1'b1) begin
      errors++;
      $display("FAIL sf_done_latency: mountDone=%b at S+2 required 1", mountDone);
    end
    checks++;
    if (partitionStart !== 32'h0 || fatStartSector !== 32'h20 || rootDirSector !== 32'h120 ||
        sectorsPerCluster !== 8'd4) begin
      errors++;
      $display("FAIL sf_layout: ps=%h fat=%h root=%h spc=%0d required 0/20/120/4",
               partitionStart, fatStartSector, rootDirSector, sectorsPerCluster);
    end
    saw_req = 1'b0;
    repeat (20) begin
      @(negedge Clock);
      if (readRequest !== 1'b0) saw_req = 1'b1;
    end
    checks++;
    if (saw_req) begin
      errors++;
      $display("FAIL sf_single_read: second readRequest seen, required none");
    end
    $display("test_superfloppy: root=%h", rootDirSector);
  endtask

  task automatic test_bad_signature();
    bit saw_req;
    pulse_start();
    ack_read();
    clear_sec();
    put_mbr(8'h0C, 32'h0000_2000);
    put_sig(8'h55, 8'h00);
    send_bytes(512, 1'b1);
    @(negedge Clock);
    checks++;
    if (mountError !== 1'b1 || errorCode !== 2'd1 || mountDone !== 1'b0) begin
      errors++;
      $display("FAIL bad_sig: err=%b code=%0d done=%b required 1/1/0", mountError, errorCode, mountDone);
    end
    saw_req = 1'b0;
    repeat (20) begin
      @(negedge Clock);
      if (readRequest !== 1'b0) saw_req = 1'b1;
    end
    checks++;
    if (saw_req) begin
      errors++;
      $display("FAIL bad_sig_no_read: readRequest seen after error, required none");
    end
    $display("test_bad_signature: code=%0d", errorCode);
  endtask

  task automatic test_bad_bpb(input logic [15:0] bps, input logic [7:0] nfat);
    pulse_start();
    ack_read();
    clear_sec();
    put_mbr(8'h0B, 32'h0000_0800);
    put_sig(8'h55, 8'hAA);
    send_bytes(512, 1'b1);
    @(negedge Clock);
    checks++;
    if (readRequest !== 1'b1 || readSector !== 32'h800) begin
      errors++;
      $display("FAIL bpb_dbr_req: req=%b sector=%h required 1/00000800", readRequest, readSector);
    end
    ack_read();
    clear_sec();
    put_bpb(bps, 8'd8, 16'h0020, nfat, 32'h0000_03C1, 32'd2);
    put_sig(8'h55, 8'hAA);
    send_bytes(512, 1'b1);
    @(negedge Clock);
    checks++;
    if (mountError !== 1'b1 || errorCode !== 2'd2 || mountDone !== 1'b0) begin
      errors++;
      $display("FAIL bad_bpb bps=%0d nfat=%0d: err=%b code=%0d done=%b required 1/2/0",
               bps, nfat, mountError, errorCode, mountDone);
    end
    $display("test_bad_bpb bps=%0d nfat=%0d: code=%0d", bps, nfat, errorCode);
  endtask

  task automatic test_no_partition();
    pulse_start();
    ack_read();
    clear_sec();
    put_mbr(8'h07, 32'h0000_2000);
    put_sig(8'h55, 8'hAA);
    send_bytes(512, 1'b1);
    @(negedge Clock);
    checks++;
    if (mountError !== 1'b1 || errorCode !== 2'd3) begin
      errors++;
      $display("FAIL no_part: err=%b code=%0d required 1/3", mountError, errorCode);
    end
    pulse_start();
    checks++;
    if (mountError !== 1'b0 || errorCode !== 2'd0 || readRequest !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: err=%b code=%0d req=%b required 0/0/1", mountError, errorCode, readRequest);
    end
    ack_read();
    clear_sec();
    send_bytes(0, 1'b1);
    @(negedge Clock);
    $display("test_no_partition: code=%0d", errorCode);
  endtask

  task automatic test_delayed_ack();
    bit unstable;
    pulse_start();
    ack_read();
    clear_sec();
    put_mbr(8'h0C, 32'h0000_2000);
    put_sig(8'h55, 8'hAA);
    send_bytes(512, 1'b1);
    @(negedge Clock);
    unstable = 1'b0;
    for (int c = 0; c < 100; c++) begin
      byteValid   = c[0];
      byteAddress = (c[1]) ? 9'h010 : 9'h00B;
      byteData    = 8'h00;
      start       = (c == 50);
      @(negedge Clock);
      if (readRequest !== 1'b1 || readSector !== 32'h2000) unstable = 1'b1;
    end
    byteValid = 1'b0;
    start     = 1'b0;
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL delayed_ack_stable: req=%b sector=%h required 1/00002000 throughout",
               readRequest, readSector);
    end
    ack_read();
    clear_sec();
    put_bpb(16'd512, 8'd8, 16'h0020, 8'd2, 32'h0000_03C1, 32'd2);
    put_sig(8'h55, 8'hAA);
    send_bytes(512, 1'b1);
    repeat (3) @(negedge Clock);
    checks++;
    if (mountDone !== 1'b1 || fatStartSector !== 32'h2020 || rootDirSector !== 32'h27A2 ||
        sectorsPerCluster !== 8'd8) begin
      errors++;
      $display("FAIL delayed_ack_result: done=%b fat=%h root=%h spc=%0d required 1/2020/27a2/8",
               mountDone, fatStartSector, rootDirSector, sectorsPerCluster);
    end
    $display("test_delayed_ack: root=%h", rootDirSector);
  endtask

  task automatic test_reset_mid_dbr();
    pulse_start();
    ack_read();
    clear_sec();
    put_mbr(8'h0C, 32'h0000_2000);
    put_sig(8'h55, 8'hAA);
    send_bytes(512, 1'b1);
    @(negedge Clock);
    ack_read();
    clear_sec();
    put_bpb(16'd512, 8'd8, 16'h0020, 8'd2, 32'h0000_03C1, 32'd2);
    send_bytes(48, 1'b0);
    #2 sys_rst = 1'b1;
    #1;
    checks++;
    if (readRequest !== 1'b0 || readSector !== 32'h0 || partitionStart !== 32'h0 ||
        mountDone !== 1'b0 || mountError !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_dbr: req=%b sec=%h ps=%h done=%b err=%b required all 0",
               readRequest, readSector, partitionStart, mountDone, mountError);
    end
    @(negedge Clock);
    sys_rst = 1'b0;
    @(negedge Clock);
    $display("test_reset_mid_dbr done");
    test_normal_mount("after_reset");
  endtask

  initial begin
    test_reset();
    test_normal_mount("first");
    test_superfloppy();
    test_bad_signature();
    test_bad_bpb(16'd512, 8'd0);
    test_bad_bpb(16'd1024, 8'd2);
    test_no_partition();
    test_delayed_ack();
    test_reset_mid_dbr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
